fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited request issue, in-order response capture,
// a DEPTH-entry prefetch queue toward decode, and redirect with stale-response dropping.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_incr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic            fire;
    logic            rsp;
    logic            push;
    logic            pop;
    logic [CW:0]     credits;
    logic [XLEN-1:0] redirect_target;

    // Queued plus in-flight fetches may never exceed DEPTH, so a response always has a slot.
    always_comb begin
        credits          = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid_o = !rst && !redirect_i && (credits < DEPTH_EXT);
        fire             = imem_req_valid_o && imem_req_ready_i;
        rsp              = imem_rsp_valid_i && !rst;
        push             = rsp && !redirect_i && (drop_cnt == '0);
        instr_valid_o    = !rst && !redirect_i && (count != '0);
        pop              = instr_valid_o && instr_ready_i;
        redirect_target  = redirect_pc_i & ~(XLEN'(3));
    end

    assign imem_addr_o = fetch_pc;
    assign instr_o     = instr_mem[rd_ptr];
    assign pc_o        = pc_mem[rd_ptr];
    assign pc_incr_o   = pc_o + XLEN'(4);

    // Redirect flushes the queue and turns every remaining in-flight fetch into a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= redirect_target;
            rsp_pc      <= redirect_target;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - CW'(rsp);
            drop_cnt    <= outstanding - CW'(rsp);
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(fire) - CW'(rsp);
            if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rsp_data_i;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

    // The credit rule makes these impossible with a well-behaved memory.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (count != DEPTH_CNT);
        end
        if (!rst && rsp) begin
            assert (outstanding != '0);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_incr_o;

    logic        w_req_valid;
    logic [31:0] w_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc_incr;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o(imem_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .pc_incr_o(pc_incr_o)
    );

    // Second instance only exercises the PC wrap from a high reset address.
    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) wrap_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(w_req_valid), .imem_req_ready_i(1'b1),
        .imem_addr_o(w_addr),
        .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .instr_valid_o(w_instr_valid), .instr_ready_i(1'b1),
        .instr_o(w_instr), .pc_o(w_pc), .pc_incr_o(w_pc_incr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
    typedef struct { logic [31:0] addr; bit stale; } fetch_t;
    typedef struct {
        bit rr; bit ir;
        bit exp_rv; logic [31:0] exp_addr; bit exp_iv; logic [31:0] exp_pc;
    } vec_t;

    entry_t      q[$];
    fetch_t      inflight[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          mem_lat;
    int          last_due;
    int          cyc;
    int          fires;
    int          checks;
    int          passes;

    bit          s_redir, s_fire, s_pop, s_rsp, s_mem_fire, s_w_fire;
    logic [31:0] s_rpc, s_mem_addr, s_w_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drives one cycle of inputs, then compares outputs with the reference model.
    task automatic apply_stimulus(input bit rr, input bit redir, input logic [31:0] rpc, input bit ir);
        bit exp_rv, exp_iv;
        imem_req_ready_i = rr;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        instr_ready_i    = ir;
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_data(mem_addr_q[0]);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
        #1;
        exp_rv = !redir && (q.size() + inflight.size() < DEPTH);
        exp_iv = !redir && (q.size() != 0);
        check_output("req_valid", 32'(imem_req_valid_o), 32'(exp_rv));
        check_output("req_addr", imem_addr_o, m_fetch_pc);
        check_output("instr_valid", 32'(instr_valid_o), 32'(exp_iv));
        if (exp_iv) begin
            check_output("instr", instr_o, q[0].instr);
            check_output("pc", pc_o, q[0].pc);
            check_output("pc_incr", pc_incr_o, q[0].pc + 32'd4);
        end
        s_redir    = redir;
        s_rpc      = rpc;
        s_fire     = exp_rv && rr;
        s_pop      = exp_iv && ir;
        s_rsp      = imem_rsp_valid_i;
        s_mem_fire = imem_req_valid_o && rr;
        s_mem_addr = imem_addr_o;
        s_w_fire   = w_req_valid;
        s_w_addr   = w_addr;
    endtask

    task automatic advance();
        fetch_t f;
        int lat, due;
        @(posedge clk);
        #1;
        if (s_rsp && mem_addr_q.size() > 0) begin
            mem_addr_q.delete(0);
            mem_due_q.delete(0);
        end
        if (s_mem_fire) begin
            lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr_q.push_back(s_mem_addr);
            mem_due_q.push_back(due);
            fires++;
        end
        if (s_redir) begin
            if (s_rsp && inflight.size() > 0) inflight.delete(0);
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            q.delete();
            m_fetch_pc = s_rpc & ~32'h3;
        end else begin
            if (s_pop && q.size() > 0) q.delete(0);
            if (s_rsp && inflight.size() > 0) begin
                f = inflight.pop_front();
                if (!f.stale) q.push_back('{instr: mem_data(f.addr), pc: f.addr});
            end
            if (s_fire) begin
                inflight.push_back('{addr: m_fetch_pc, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        w_rsp_valid = s_w_fire;
        w_rsp_data  = mem_data(s_w_addr);
        cyc++;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
        redirect_i       = 1'b0;
        instr_ready_i    = 1'b0;
        w_rsp_valid      = 1'b0;
        #1;
        check_output("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check_output("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        check_output("rst_wrap_req_valid", 32'(w_req_valid), 32'd0);
        @(posedge clk);
        #1;
        mem_addr_q.delete();
        mem_due_q.delete();
        q.delete();
        inflight.delete();
        m_fetch_pc  = 32'h0;
        last_due    = cyc;
        w_rsp_valid = 1'b0;
        cyc++;
        rst = 1'b0;
    endtask

    // Waits a bounded number of cycles for the first instruction after a redirect.
    task automatic expect_first_pc(input string name, input logic [31:0] target);
        bit seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
            if (instr_valid_o) begin
                seen = 1'b1;
                check_output(name, pc_o, target);
            end
            advance();
        end
        if (!seen) check_output({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        vec_t vecs[9];
        int   snap;
        bit   wait_rsp;
        checks = 0; passes = 0; cyc = 0; fires = 0; mem_lat = 1; last_due = 0;
        m_fetch_pc = 32'h0;

        vecs[0] = '{rr:1, ir:0, exp_rv:1, exp_addr:32'h00, exp_iv:0, exp_pc:32'h0};
        vecs[1] = '{rr:1, ir:0, exp_rv:1, exp_addr:32'h04, exp_iv:0, exp_pc:32'h0};
        vecs[2] = '{rr:1, ir:0, exp_rv:1, exp_addr:32'h08, exp_iv:1, exp_pc:32'h0};
        vecs[3] = '{rr:1, ir:0, exp_rv:1, exp_addr:32'h0C, exp_iv:1, exp_pc:32'h0};
        vecs[4] = '{rr:1, ir:0, exp_rv:0, exp_addr:32'h10, exp_iv:1, exp_pc:32'h0};
        vecs[5] = '{rr:1, ir:1, exp_rv:0, exp_addr:32'h10, exp_iv:1, exp_pc:32'h0};
        vecs[6] = '{rr:1, ir:0, exp_rv:1, exp_addr:32'h10, exp_iv:1, exp_pc:32'h4};
        vecs[7] = '{rr:1, ir:0, exp_rv:0, exp_addr:32'h14, exp_iv:1, exp_pc:32'h4};
        vecs[8] = '{rr:1, ir:0, exp_rv:0, exp_addr:32'h14, exp_iv:1, exp_pc:32'h4};

        // Streaming from reset, with the wrap instance running alongside.
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
            if (k >= 2) begin
                check_output("stream_valid", 32'(instr_valid_o), 32'd1);
                check_output("stream_pc", pc_o, 32'(4 * (k - 2)));
            end
            if (k >= 2 && k <= 5) begin
                check_output("wrap_valid", 32'(w_instr_valid), 32'd1);
                check_output("wrap_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
                check_output("wrap_pc_incr", w_pc_incr, 32'hFFFF_FFFC + 32'(4 * (k - 2)));
                check_output("wrap_instr", w_instr, mem_data(32'hFFFF_FFF8 + 32'(4 * (k - 2))));
            end
            advance();
        end

        // Decode backpressure fills the credits, then one pop reopens fetch.
        do_reset();
        mem_lat = 1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rr, 1'b0, 32'h0, vecs[i].ir);
            check_output("bp_req_valid", 32'(imem_req_valid_o), 32'(vecs[i].exp_rv));
            check_output("bp_addr", imem_addr_o, vecs[i].exp_addr);
            check_output("bp_instr_valid", 32'(instr_valid_o), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) check_output("bp_pc", pc_o, vecs[i].exp_pc);
            advance();
        end

        // Memory not ready: address holds, no duplicate fetch.
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
            advance();
        end
        snap = fires;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
            check_output("stall_addr", imem_addr_o, 32'h8);
            check_output("stall_req_valid", 32'(imem_req_valid_o), 32'd1);
            advance();
        end
        check_output("stall_no_fire", 32'(fires - snap), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        check_output("stall_release_addr", imem_addr_o, 32'h8);
        advance();
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        check_output("stall_next_addr", imem_addr_o, 32'hC);
        advance();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
            advance();
        end

        // Redirect with one queued entry and two fetches in flight.
        do_reset();
        mem_lat = 3;
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0); advance();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0); advance();
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0); advance();
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0); advance();
        apply_stimulus(1'b1, 1'b1, 32'h103, 1'b1);
        check_output("redir_req_valid", 32'(imem_req_valid_o), 32'd0);
        check_output("redir_instr_valid", 32'(instr_valid_o), 32'd0);
        advance();
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        check_output("redir_flushed", 32'(instr_valid_o), 32'd0);
        check_output("redir_addr", imem_addr_o, 32'h100);
        advance();
        expect_first_pc("redir_first_pc", 32'h100);

        // Redirect in the same cycle as the only outstanding response.
        do_reset();
        mem_lat = 2;
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1); advance();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1); advance();
        apply_stimulus(1'b1, 1'b1, 32'h200, 1'b1);
        wait_rsp = imem_rsp_valid_i;
        if (!wait_rsp) $display("[TB] note: coincident response not present");
        advance();
        expect_first_pc("coinc_first_pc", 32'h200);

        // Randomized traffic with a reset dropped in mid-stream.
        mem_lat = 0;
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                do_reset();
                apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
                check_output("midrst_instr_valid", 32'(instr_valid_o), 32'd0);
                check_output("midrst_addr", imem_addr_o, 32'h0);
                check_output("midrst_req_valid", 32'(imem_req_valid_o), 32'd1);
                advance();
            end
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                           $urandom, $urandom_range(0, 2) != 0);
            advance();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
